// File: rtl/pong_pkg.sv
// Shared types for the Pong ball engine: game states, sound and channel codes,
// and the saturating speed helpers used on paddle hits.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GOAL  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SND_PING = 2'd1,
    SND_PONG = 2'd2,
    SND_GOAL = 2'd3
  } sound_e;

  typedef enum logic [1:0] {
    CH_NONE  = 2'd0,
    CH_RIGHT = 2'd1,
    CH_LEFT  = 2'd2,
    CH_BOTH  = 2'd3
  } chan_e;

  function automatic logic [2:0] speed_up(input logic [2:0] v, input logic [2:0] vmax);
    return (v >= vmax) ? vmax : v + 3'd1;
  endfunction

  function automatic logic [2:0] speed_down(input logic [2:0] v);
    return (v <= 3'd1) ? 3'd1 : v - 3'd1;
  endfunction

endpackage

// File: rtl/pong_sound_timer.sv
// Sound event arbiter: goal beats pong beats ping; the winning event loads
// sound, channel and a duration timer that silences the channel when it expires.
module pong_sound_timer
  import pong_pkg::*;
#(
  parameter int T_PING = 10,
  parameter int T_PONG = 30,
  parameter int T_GOAL = 40
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       ping,
  input  chan_e      ping_ch,
  input  logic       pong,
  input  chan_e      pong_ch,
  input  logic       goal,
  input  chan_e      goal_ch,
  output logic [1:0] sound,
  output logic [1:0] channel
);

  localparam int T_MAX = (T_PING > T_PONG) ? ((T_PING > T_GOAL) ? T_PING : T_GOAL)
                                           : ((T_PONG > T_GOAL) ? T_PONG : T_GOAL);
  localparam int TW = $clog2(T_MAX + 1);

  logic [TW-1:0] timer;

  // NOTE: registers are written with non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge dyn_clk) begin
    if (reset) begin
      sound   <= SND_PING;
      channel <= CH_NONE;
      timer   <= '0;
    end else if (goal) begin
      sound   <= SND_GOAL;
      channel <= goal_ch;
      timer   <= TW'(T_GOAL);
    end else if (pong) begin
      sound   <= SND_PONG;
      channel <= pong_ch;
      timer   <= TW'(T_PONG);
    end else if (ping) begin
      sound   <= SND_PING;
      channel <= ping_ch;
      timer   <= TW'(T_PING);
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
      if (timer == TW'(1)) channel <= CH_NONE;
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/play/goal/over FSM, ball motion with wall and paddle
// collisions, progressive speed, scoring and sound event generation.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int W_SCREEN      = 800,
  parameter int H_SCREEN      = 600,
  parameter int BALL          = 10,
  parameter int PAD_H         = 80,
  parameter int PAD_W         = 10,
  parameter int PAD_OFF       = 20,
  parameter int SPEED_INIT    = 2,
  parameter int SPEED_MAX     = 7,
  parameter int HITS_PER_STEP = 4,
  parameter int SERVE_TICKS   = 60,
  parameter int WIN_SCORE     = 9,
  parameter int T_PING        = 10,
  parameter int T_PONG        = 30,
  parameter int T_GOAL        = 40
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       play,
  input  logic [9:0] pos_ply1,
  input  logic [9:0] pos_ply2,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       goal_ply1,
  output logic       goal_ply2,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] sound,
  output logic [1:0] channel
);

  localparam logic [10:0] BALL_W = 11'(BALL);
  localparam logic [10:0] HALF   = 11'(BALL / 2);
  localparam logic [10:0] PAD_HW = 11'(PAD_H);
  localparam logic [10:0] ZONE_LO = 11'(PAD_H / 4);
  localparam logic [10:0] ZONE_HI = 11'(3 * PAD_H / 4);
  localparam logic [10:0] L_FACE = 11'(PAD_OFF + PAD_W);
  localparam logic [10:0] R_FACE = 11'(W_SCREEN - PAD_OFF - PAD_W);
  localparam logic [10:0] X_MAX  = 11'(W_SCREEN - BALL);
  localparam logic [10:0] Y_MAX  = 11'(H_SCREEN - BALL);
  localparam logic [9:0]  X_CTR  = 10'(W_SCREEN / 2 - BALL / 2);
  localparam logic [9:0]  Y_CTR  = 10'(H_SCREEN / 2 - BALL / 2);
  localparam logic [2:0]  S_INIT = 3'(SPEED_INIT);
  localparam logic [2:0]  S_MAX  = 3'(SPEED_MAX);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam int HW = $clog2(HITS_PER_STEP + 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_STEP - 1);

  state_e        state, state_nxt;
  logic [9:0]    x_nxt, y_nxt;
  logic          dx, dy, dx_nxt, dy_nxt;
  logic [2:0]    speed_x, speed_y, speed_x_nxt, speed_y_nxt;
  logic [HW-1:0] hit_cnt, hit_cnt_nxt;
  logic [SW-1:0] serve_cnt, serve_cnt_nxt;
  logic [3:0]    score1_nxt, score2_nxt;
  logic          goal1_nxt, goal2_nxt, game_over_nxt, winner_nxt;
  logic          ping_ev, pong_ev, goal_ev;
  chan_e         pong_ch, goal_ch;

  // Collision arithmetic is done in 11 bits so sums never wrap.
  logic [10:0] xw, yw, sx, sy, p1w, p2w, pad_top, ctr;
  logic        hit_l, hit_r, outer_zone;

  assign xw  = {1'b0, x_ball};
  assign yw  = {1'b0, y_ball};
  assign sx  = {8'd0, speed_x};
  assign sy  = {8'd0, speed_y};
  assign p1w = {1'b0, pos_ply1};
  assign p2w = {1'b0, pos_ply2};

  assign hit_l = !dx && (xw >= L_FACE) && ((xw - sx) <= L_FACE)
              && ((yw + BALL_W) > p1w) && (yw < (p1w + PAD_HW));
  assign hit_r = dx && ((xw + BALL_W) <= R_FACE) && ((xw + BALL_W + sx) >= R_FACE)
              && ((yw + BALL_W) > p2w) && (yw < (p2w + PAD_HW));

  assign pad_top    = hit_l ? p1w : p2w;
  assign ctr        = yw + HALF;
  assign outer_zone = (ctr < (pad_top + ZONE_LO)) || (ctr >= (pad_top + ZONE_HI));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_nxt     = state;
    x_nxt         = x_ball;
    y_nxt         = y_ball;
    dx_nxt        = dx;
    dy_nxt        = dy;
    speed_x_nxt   = speed_x;
    speed_y_nxt   = speed_y;
    hit_cnt_nxt   = hit_cnt;
    serve_cnt_nxt = serve_cnt;
    score1_nxt    = score1;
    score2_nxt    = score2;
    goal1_nxt     = 1'b0;
    goal2_nxt     = 1'b0;
    game_over_nxt = game_over;
    winner_nxt    = winner;
    ping_ev       = 1'b0;
    pong_ev       = 1'b0;
    goal_ev       = 1'b0;
    pong_ch       = CH_NONE;
    goal_ch       = CH_NONE;

    if (play) begin
      case (state)
        ST_SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            state_nxt     = ST_PLAY;
            serve_cnt_nxt = '0;
            speed_x_nxt   = S_INIT;
            speed_y_nxt   = S_INIT;
            hit_cnt_nxt   = '0;
          end else begin
            serve_cnt_nxt = serve_cnt + 1'b1;
          end
        end

        ST_PLAY: begin
          if (!dy && (yw < sy)) begin
            y_nxt   = '0;
            dy_nxt  = 1'b1;
            ping_ev = 1'b1;
          end else if (dy && ((yw + sy) >= Y_MAX)) begin
            y_nxt   = Y_MAX[9:0];
            dy_nxt  = 1'b0;
            ping_ev = 1'b1;
          end else begin
            y_nxt = dy ? y_ball + 10'(speed_y) : y_ball - 10'(speed_y);
          end

          if (hit_l || hit_r) begin
            x_nxt   = hit_l ? L_FACE[9:0] : 10'(R_FACE - BALL_W);
            dx_nxt  = hit_l;
            pong_ev = 1'b1;
            pong_ch = hit_l ? CH_LEFT : CH_RIGHT;
            if (hit_cnt == HIT_LAST) begin
              hit_cnt_nxt = '0;
              speed_x_nxt = speed_up(speed_x, S_MAX);
            end else begin
              hit_cnt_nxt = hit_cnt + 1'b1;
            end
            speed_y_nxt = outer_zone ? speed_up(speed_y, S_MAX) : speed_down(speed_y);
          end else if (!dx && (xw < sx)) begin
            x_nxt      = '0;
            score2_nxt = score2 + 4'd1;
            goal2_nxt  = 1'b1;
            goal_ev    = 1'b1;
            goal_ch    = CH_LEFT;
            state_nxt  = ST_GOAL;
          end else if (dx && ((xw + sx) >= X_MAX)) begin
            x_nxt      = X_MAX[9:0];
            score1_nxt = score1 + 4'd1;
            goal1_nxt  = 1'b1;
            goal_ev    = 1'b1;
            goal_ch    = CH_RIGHT;
            state_nxt  = ST_GOAL;
          end else begin
            x_nxt = dx ? x_ball + 10'(speed_x) : x_ball - 10'(speed_x);
          end
        end

        // dx still points at the side that conceded, which is the next serve direction.
        ST_GOAL: begin
          if ((score1 == WIN) || (score2 == WIN)) begin
            state_nxt     = ST_OVER;
            game_over_nxt = 1'b1;
            winner_nxt    = (score2 == WIN);
          end else begin
            state_nxt = ST_SERVE;
            x_nxt     = X_CTR;
            y_nxt     = Y_CTR;
          end
        end

        ST_OVER: ;
      endcase
    end
  end

  always_ff @(posedge dyn_clk) begin
    if (reset) begin
      state     <= ST_SERVE;
      x_ball    <= X_CTR;
      y_ball    <= Y_CTR;
      dx        <= 1'b1;
      dy        <= 1'b1;
      speed_x   <= S_INIT;
      speed_y   <= S_INIT;
      hit_cnt   <= '0;
      serve_cnt <= '0;
      score1    <= '0;
      score2    <= '0;
      goal_ply1 <= 1'b0;
      goal_ply2 <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      state     <= state_nxt;
      x_ball    <= x_nxt;
      y_ball    <= y_nxt;
      dx        <= dx_nxt;
      dy        <= dy_nxt;
      speed_x   <= speed_x_nxt;
      speed_y   <= speed_y_nxt;
      hit_cnt   <= hit_cnt_nxt;
      serve_cnt <= serve_cnt_nxt;
      score1    <= score1_nxt;
      score2    <= score2_nxt;
      goal_ply1 <= goal1_nxt;
      goal_ply2 <= goal2_nxt;
      game_over <= game_over_nxt;
      winner    <= winner_nxt;
    end
  end

  pong_sound_timer #(
    .T_PING(T_PING),
    .T_PONG(T_PONG),
    .T_GOAL(T_GOAL)
  ) u_sound (
    .dyn_clk (dyn_clk),
    .reset   (reset),
    .ping    (ping_ev),
    .ping_ch (CH_BOTH),
    .pong    (pong_ev),
    .pong_ch (pong_ch),
    .goal    (goal_ev),
    .goal_ch (goal_ch),
    .sound   (sound),
    .channel (channel)
  );

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomised game play against a signed-velocity reference model of the Pong
// rules, with directed serve, pause, game-over freeze and reset-in-goal steps.
module tb_pong_ball_engine;

  localparam int W = 800, H = 600, BALL = 10, PAD_H = 80;
  localparam int LF = 30, RF = 770;
  localparam int SPEED_INIT = 2, SPEED_MAX = 7, HITS = 4, SERVE_TICKS = 60, WIN = 9;
  localparam int T_PING = 10, T_PONG = 30, T_GOAL = 40;
  localparam int S_SERVE = 0, S_PLAY = 1, S_GOAL = 2, S_OVER = 3;

  logic       dyn_clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic [9:0] pos_ply1 = '0, pos_ply2 = '0;
  logic [9:0] x_ball, y_ball;
  logic [3:0] score1, score2;
  logic       goal_ply1, goal_ply2, game_over, winner;
  logic [1:0] sound, channel;

  pong_ball_engine dut (
    .dyn_clk  (dyn_clk),
    .reset    (reset),
    .play     (play),
    .pos_ply1 (pos_ply1),
    .pos_ply2 (pos_ply2),
    .x_ball   (x_ball),
    .y_ball   (y_ball),
    .score1   (score1),
    .score2   (score2),
    .goal_ply1(goal_ply1),
    .goal_ply2(goal_ply2),
    .game_over(game_over),
    .winner   (winner),
    .sound    (sound),
    .channel  (channel)
  );

  always #5 dyn_clk = ~dyn_clk;

  int n_vec = 0, n_err = 0;
  int skill1 = 50, skill2 = 50;

  // Reference model state: position, signed-direction flags, speeds, scores, sound.
  int m_st, m_x, m_y, m_sx, m_sy, m_hits, m_cnt, m_s1, m_s2;
  bit m_right, m_down, m_g1, m_g2, m_over, m_win;
  int m_snd, m_chan, m_rem;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_SERVE; m_x = W/2 - BALL/2; m_y = H/2 - BALL/2;
    m_right = 1; m_down = 1; m_sx = SPEED_INIT; m_sy = SPEED_INIT;
    m_hits = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_g1 = 0; m_g2 = 0;
    m_over = 0; m_win = 0; m_snd = 1; m_chan = 0; m_rem = 0;
  endtask

  task automatic model_step(input bit pl, input int p1, input int p2);
    int vx, vy, nx, ny, pad, off, pong_c, goal_c;
    bit ping_e, pong_e, goal_e, hl, hr;
    ping_e = 0; pong_e = 0; goal_e = 0; pong_c = 0; goal_c = 0;
    m_g1 = 0; m_g2 = 0;
    if (pl) begin
      case (m_st)
        S_SERVE: begin
          if (m_cnt == SERVE_TICKS - 1) begin
            m_st = S_PLAY; m_cnt = 0; m_sx = SPEED_INIT; m_sy = SPEED_INIT; m_hits = 0;
          end else m_cnt++;
        end
        S_PLAY: begin
          vx = m_right ? m_sx : -m_sx;
          vy = m_down ? m_sy : -m_sy;
          ny = m_y + vy;
          if (!m_down && ny < 0) begin ny = 0; m_down = 1; ping_e = 1; end
          else if (m_down && ny >= H - BALL) begin ny = H - BALL; m_down = 0; ping_e = 1; end
          hl = !m_right && m_x >= LF && m_x + vx <= LF && m_y + BALL > p1 && m_y < p1 + PAD_H;
          hr = m_right && m_x + BALL <= RF && m_x + BALL + vx >= RF && m_y + BALL > p2 && m_y < p2 + PAD_H;
          if (hl || hr) begin
            nx = hl ? LF : RF - BALL;
            m_right = hl; pong_e = 1; pong_c = hl ? 2 : 1;
            m_hits++;
            if (m_hits == HITS) begin m_hits = 0; if (m_sx < SPEED_MAX) m_sx++; end
            pad = hl ? p1 : p2;
            off = m_y + BALL/2 - pad;
            if (off < PAD_H/4 || off >= 3*PAD_H/4) begin if (m_sy < SPEED_MAX) m_sy++; end
            else if (m_sy > 1) m_sy--;
          end else if (!m_right && m_x + vx < 0) begin
            nx = 0; m_s2++; m_g2 = 1; goal_e = 1; goal_c = 2; m_st = S_GOAL;
          end else if (m_right && m_x + vx >= W - BALL) begin
            nx = W - BALL; m_s1++; m_g1 = 1; goal_e = 1; goal_c = 1; m_st = S_GOAL;
          end else nx = m_x + vx;
          m_x = nx; m_y = ny;
        end
        S_GOAL: begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_st = S_OVER; m_over = 1; m_win = (m_s2 == WIN);
          end else begin
            m_st = S_SERVE; m_x = W/2 - BALL/2; m_y = H/2 - BALL/2;
          end
        end
        default: ;
      endcase
    end
    if (goal_e) begin m_snd = 3; m_chan = goal_c; m_rem = T_GOAL; end
    else if (pong_e) begin m_snd = 2; m_chan = pong_c; m_rem = T_PONG; end
    else if (ping_e) begin m_snd = 1; m_chan = 3; m_rem = T_PING; end
    else if (m_rem > 0) begin m_rem--; if (m_rem == 0) m_chan = 0; end
  endtask

  task automatic compare_all();
    check("x_ball", int'(x_ball), m_x);
    check("y_ball", int'(y_ball), m_y);
    check("score1", int'(score1), m_s1);
    check("score2", int'(score2), m_s2);
    check("goal_ply1", int'(goal_ply1), int'(m_g1));
    check("goal_ply2", int'(goal_ply2), int'(m_g2));
    check("game_over", int'(game_over), int'(m_over));
    check("winner", int'(winner), int'(m_win));
    check("sound", int'(sound), m_snd);
    check("channel", int'(channel), m_chan);
  endtask

  task automatic tick(input bit rst, input bit pl, input int p1, input int p2);
    reset = rst; play = pl; pos_ply1 = 10'(p1); pos_ply2 = 10'(p2);
    @(posedge dyn_clk);
    #1;
    if (rst) model_reset(); else model_step(pl, p1, p2);
    compare_all();
  endtask

  // A skilled paddle keeps the ball centre inside its span; otherwise it wanders.
  function automatic int pick_pad(input int skill);
    int p;
    if (int'($urandom_range(0, 99)) < skill) begin
      p = m_y + BALL/2 - int'($urandom_range(0, PAD_H - 1));
      if (p < 0) p = 0;
    end else p = int'($urandom_range(0, 600));
    return p;
  endfunction

  task automatic random_tick(input int play_pct);
    if (m_st == S_SERVE) begin
      skill1 = int'($urandom_range(0, 75));
      skill2 = int'($urandom_range(0, 75));
    end
    tick(0, int'($urandom_range(0, 99)) < play_pct, pick_pad(skill1), pick_pad(skill2));
  endtask

  initial begin
    int budget, hold_x, hold_y;

    // Reset values
    tick(1, 0, 300, 300);
    check("reset_x", int'(x_ball), 395);
    check("reset_y", int'(y_ball), 295);
    check("reset_sound", int'(sound), 1);

    // Serve: centred for SERVE_TICKS play ticks, then the first diagonal move
    for (int i = 0; i < SERVE_TICKS; i++) tick(0, 1, 300, 300);
    check("serve_hold_x", int'(x_ball), 395);
    tick(0, 1, 300, 300);
    check("first_move_x", int'(x_ball), 397);
    check("first_move_y", int'(y_ball), 297);

    // Fly until a sound event in play, then pause mid-flight for 20 ticks
    budget = 0;
    while (!(m_st == S_PLAY && m_chan != 0) && budget < 3000) begin
      random_tick(100);
      budget++;
    end
    check("sound_event_seen", int'(channel != 2'd0), 1);
    hold_x = m_x; hold_y = m_y;
    for (int i = 0; i < 20; i++) tick(0, 0, int'($urandom_range(0, 600)), int'($urandom_range(0, 600)));
    check("pause_hold_x", int'(x_ball), hold_x);
    check("pause_hold_y", int'(y_ball), hold_y);

    // Random full game to a winner
    budget = 0;
    while (m_st != S_OVER && budget < 60000) begin
      random_tick(92);
      budget++;
    end
    check("game_finished", int'(game_over), 1);

    // Game over is frozen until reset
    for (int i = 0; i < 30; i++) random_tick(100);
    check("over_frozen_x", int'(x_ball), m_x);

    // Fresh game, reset while in GOAL
    tick(1, 0, 0, 0);
    budget = 0;
    while (m_st != S_GOAL && budget < 20000) begin
      random_tick(95);
      budget++;
    end
    check("goal_reached", int'(goal_ply1 | goal_ply2), 1);
    tick(1, 1, 0, 0);
    check("goal_reset_x", int'(x_ball), 395);
    check("goal_reset_score", int'(score1) + int'(score2), 0);
    for (int i = 0; i < 5; i++) random_tick(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised ball engine for the Pong game, clocked by the dynamic (frame-rate) tick. Adds a serve/play/goal/game-over state machine, internal score keeping with a win limit, progressive ball speed on paddle hits, paddle-zone vertical deflection, and prioritised sound events with timed channels. Sits between the player-position logic and the video/sound renderers, replacing the fixed-size ball mover.

## Interface
- W_SCREEN, 800, court width in pixels
- H_SCREEN, 600, court height in pixels
- BALL, 10, ball side in pixels
- PAD_H, 80, paddle height
- PAD_W, 10, paddle width
- PAD_OFF, 20, distance from court edge to paddle outer side
- SPEED_INIT, 2, serve speed on both axes; range 1..SPEED_MAX
- SPEED_MAX, 7, speed ceiling; must be ≤7
- HITS_PER_STEP, 4, paddle hits per +1 of speed_x
- SERVE_TICKS, 60, pause before each serve
- WIN_SCORE, 9, points to win; range 1..15
- T_PING, 10; T_PONG, 30; T_GOAL, 40: sound durations in ticks

Ports:
- dyn_clk  in  1  dynamic tick clock
- reset  in  1  reset reset, synchronous, active-high; clock dyn_clk
- play  in  1  level; 1 = run, 0 = pause
- pos_ply1, pos_ply2  in  10  paddle top y, left/right
- x_ball, y_ball  out  10  ball top-left corner
- score1, score2  out  4  points, left/right player
- goal_ply1, goal_ply2  out  1  one-tick pulse: point to that player
- game_over  out  1  high in OVER
- winner  out  1  0 = ply1, 1 = ply2; valid while game_over
- sound  out  2  1 ping, 2 pong, 3 goal
- channel  out  2  0 none, 1 right, 2 left, 3 both

## Operation
- States: SERVE, PLAY, GOAL, OVER.
- Reset values: state SERVE, ball (W/2−BALL/2, H/2−BALL/2) = (395,295), dx=1, dy=1, speed_x=speed_y=SPEED_INIT, hit count 0, serve counter 0, scores 0, all pulses 0, game_over 0, winner 0, sound 1, channel 0.
- SERVE: ball centred. Serve counter increments on ticks with play=1. At SERVE_TICKS−1, go to PLAY, reset speeds and hit count, clear the counter.
- PLAY: one move per tick with play=1. Speeds are unsigned 3-bit. Compares use 11-bit arithmetic, so no wrap.
  - Top wall, dy=0 and y<speed_y: y←0, dy←1, ping event, channel both.
  - Bottom wall, dy=1 and y+speed_y ≥ H−BALL: y←H−BALL, dy←0, ping event, channel both.
  - Left paddle, all of:
    - dx=0
    - x ≥ PAD_OFF+PAD_W
    - x−speed_x ≤ PAD_OFF+PAD_W
    - y+BALL > pos_ply1 and y < pos_ply1+PAD_H
  - On left paddle hit: x←PAD_OFF+PAD_W, dx←1, pong event, channel left.
  - Right paddle: mirror image, face at W−PAD_OFF−PAD_W. Ball clamped to face−BALL, dx←0, pong event, channel right.
  - Paddle hit side effects:
    - Hit count increments. On reaching HITS_PER_STEP it clears and speed_x+1, saturating at SPEED_MAX.
    - Contact zone is ball centre offset from paddle top. Outer quarters: speed_y+1, sat SPEED_MAX. Middle half: speed_y−1, floor 1.
  - Goal left, no paddle hit, dx=0 and x<speed_x: x←0, score2+1, goal_ply2 pulse, goal event, channel left, go to GOAL.
  - Goal right, no paddle hit, dx=1 and x+speed_x ≥ W−BALL: x←W−BALL, score1+1, goal_ply1 pulse, goal event, channel right, go to GOAL.
  - Otherwise x and y advance by ±speed.
- GOAL: ball holds for 1 tick.
  - If a score equals WIN_SCORE: go to OVER, winner set.
  - Else: go to SERVE, dx set toward the conceding side (point to ply2 → dx=0).
- OVER: everything frozen, game_over=1. Only reset exits.
- Sound:
  - Within one tick, priority is goal > pong > ping. Same-tick wall and paddle events apply both motion updates, but only the top-priority sound.
  - An event loads sound, channel and a timer (T_*). The timer counts down every tick, including while paused. At 0, channel←none. A new event restarts the timer.
- play=0: position, state and serve counter hold. Pulses stay 0.
- Reset mid-game or mid-sound: all values return to reset values on that edge.

## Timing
- All outputs registered; updates appear 1 tick after the triggering edge.
- goal_ply* is high for exactly the tick in which state=GOAL.
- Serve to first move: SERVE_TICKS play-ticks.
- A goal on tick n gives GOAL at n+1, then SERVE or OVER at n+2.

## Structure
- Shared package pong_pkg holds:
  - state enum
  - sound codes (ping/pong/goal)
  - channel codes (none/right/left/both)
- One sub-module, pong_sound_timer: event priority mux, duration counter, and sound/channel registers. Inputs: three event strobes and channels.
- Motion, collision, speed and FSM logic live in pong_ball_engine.

## Test plan
- Reset, then 60 ticks with play=1: ball stays at (395,295) until the 60th tick, then moves to (397,297).
- Ball at y=1, dy=0, speed 2: next y=0, dy=1, sound=1, channel=3 for 10 ticks, then 0.
- Ball x=31, dx=0, pos_ply1 overlapping: x←30, dx=1, sound=2, channel=2. Four such hits raise speed_x from 2 to 3.
- Ball x=1, dx=0, paddle absent:
  - goal_ply2 is high for one tick, score2=1, channel=2.
  - The next serve moves with dx=0.
- score1=8, right goal:
  - score1=9, game_over=1, winner=0.
  - Further ticks change nothing until reset.
- play=0 mid-flight for 20 ticks: position frozen, sound channel still times out. Reset during GOAL: all outputs return to reset values next edge.
